// File: rtl/mips32_pkg.sv
// ---------------------------------------------------------------------------
// mips32_pkg
// Shared definitions for the MIPS32 pipeline front-end:
//   - six-bit opcode constants for the supported instruction set
//   - instruction-type classification used by decode and later stages
//   - fetch_entry_t, the {instruction, next-PC} pair that travels from fetch
//     to decode
//   - small helpers to classify an instruction word by its opcode
// ---------------------------------------------------------------------------
package mips32_pkg;

  // Register-register ALU operations
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;

  // Memory access
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;

  // Register-immediate ALU operations
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;

  // Conditional branches
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;

  // Halt: fetch stops once this word has been queued
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    RR_ALU,
    RM_ALU,
    LOAD,
    STORE,
    BRANCH,
    HALT
  } instr_type_e;

  // One prefetch queue entry: the fetched word and the address after it
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } fetch_entry_t;

  function automatic logic isHalt(input logic [31:0] ir);
    return (ir[31:26] == OP_HLT);
  endfunction

  // Unknown opcodes are treated as register-register ALU operations so
  // that decode always sees a legal type.
  function automatic instr_type_e instrType(input logic [31:0] ir);
    instr_type_e t;
    case (ir[31:26])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     t = RM_ALU;
      OP_LW:                                         t = LOAD;
      OP_SW:                                         t = STORE;
      OP_BNEQZ, OP_BEQZ:                             t = BRANCH;
      OP_HLT:                                        t = HALT;
      default:                                       t = RR_ALU;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mips32_fetch_queue.sv
// ---------------------------------------------------------------------------
// mips32_fetch_queue
// Synchronous FIFO of DEPTH fetch entries with first-word-fall-through head.
// While the queue is empty the head output keeps showing the last entry that
// was presented, so decode sees stable values between instructions.
//
// Ports:
//   i_clk     clock, rising edge
//   i_reset   synchronous active-high reset
//   i_enq     write i_entry at the tail
//   i_entry   entry to write
//   i_deq     consume the head (ignored while empty)
//   i_flush   discard all entries; wins over enqueue and dequeue
//   o_valid   head holds a live entry
//   o_head    head entry (or last presented entry while empty)
//   o_count   number of live entries, 0..DEPTH
// ---------------------------------------------------------------------------
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_enq,
  input  fetch_entry_t               i_entry,
  input  logic                       i_deq,
  input  logic                       i_flush,
  output logic                       o_valid,
  output fetch_entry_t               o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  fetch_entry_t   r_lastHead;
  logic [PW-1:0]  r_wrPtr;
  logic [PW-1:0]  r_rdPtr;
  logic [PW:0]    r_count;

  logic           w_notEmpty;
  logic           w_doEnq;
  logic           w_doDeq;

  assign w_notEmpty = (r_count != '0);
  assign w_doEnq    = i_enq && !i_flush;
  assign w_doDeq    = i_deq && w_notEmpty && !i_flush;

  // Pointer and occupancy bookkeeping. A flush returns everything to the
  // empty state; the remembered head is still refreshed so the value shown
  // during the flush cycle is what lingers afterwards.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_lastHead <= '0;
    end else begin
      if (w_notEmpty) begin
        r_lastHead <= r_mem[r_rdPtr];
      end
      if (i_flush) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
        r_count <= '0;
      end else begin
        if (w_doEnq) begin
          r_wrPtr <= r_wrPtr + PTR_ONE;
        end
        if (w_doDeq) begin
          r_rdPtr <= r_rdPtr + PTR_ONE;
        end
        case ({w_doEnq, w_doDeq})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage array; no reset needed because the head mux never exposes an
  // unwritten slot.
  always_ff @(posedge i_clk) begin
    if (w_doEnq) begin
      r_mem[r_wrPtr] <= i_entry;
    end
  end

  assign o_valid = w_notEmpty;
  assign o_head  = w_notEmpty ? r_mem[r_rdPtr] : r_lastHead;
  assign o_count = r_count;

  // The fetch unit's credit scheme must keep the queue from overflowing
  assert property (@(posedge i_clk) disable iff (i_reset)
    !(w_doEnq && (r_count == CNT_FULL)));

endmodule

// File: rtl/mips32_fetch_unit.sv
// ---------------------------------------------------------------------------
// mips32_fetch_unit
// Instruction fetch front-end. Owns the word-addressed PC, issues reads to a
// variable-latency instruction memory, buffers returned words in a prefetch
// queue and presents them to decode as {ir, npc} pairs over valid/ready.
// A taken branch flushes the queue and discards every in-flight response.
// Fetching stops after an HLT word has been queued until the next redirect.
//
// Ports:
//   clk1          clock, rising edge
//   reset         synchronous active-high reset
//   imem_req      read request (address on imem_addr)
//   imem_addr     word address of the request (the PC)
//   imem_gnt      memory accepted the request this cycle
//   imem_rvalid   read data valid, responses in request order
//   imem_rdata    returned instruction word
//   br_taken      one-cycle redirect strobe from execute
//   br_target     redirect word address, low AW bits used
//   id_valid      queue head valid for decode
//   id_ready      decode accepts the head
//   id_ir         head instruction
//   id_npc        head fetch address + 1, zero-extended
//   fetch_halted  HLT queued, fetch stopped
// ---------------------------------------------------------------------------
module mips32_fetch_unit
  import mips32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic          clk1,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  input  logic          br_taken,
  input  logic [31:0]   br_target,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_ir,
  output logic [31:0]   id_npc,
  output logic          fetch_halted
);

  localparam int CW = $clog2(DEPTH);
  localparam logic [AW-1:0] RESET_PC_W   = AW'(RESET_PC);
  localparam logic [AW-1:0] ADDR_ONE     = AW'(1);
  localparam logic [CW:0]   CNT_ONE      = (CW + 1)'(1);
  localparam logic [CW+1:0] CREDIT_LIMIT = (CW + 2)'(DEPTH);

  logic [AW-1:0]  r_pc;
  logic [AW-1:0]  r_respPc;
  logic [CW:0]    r_outstanding;
  logic [CW:0]    r_drop;
  logic           r_stopped;

  logic [CW:0]    w_occ;
  logic [CW+1:0]  w_inFlight;
  logic           w_req;
  logic           w_fire;
  logic           w_enq;
  logic           w_deq;
  logic [CW:0]    w_outAfter;
  logic [AW-1:0]  w_target;
  fetch_entry_t   w_enqEntry;
  fetch_entry_t   w_head;
  logic           w_unused;

  assign w_target = br_target[AW-1:0];
  assign w_unused = &{1'b0, br_target[31:AW]};

  // Credit check: queued words plus words still in flight may never exceed
  // the queue depth, so every response is guaranteed a free slot.
  assign w_inFlight = {1'b0, w_occ} + {1'b0, r_outstanding};
  assign w_req      = !reset && !r_stopped && !br_taken && (w_inFlight < CREDIT_LIMIT);
  assign w_fire     = w_req && imem_gnt;

  // A response is only kept when no branch is redirecting this cycle, no
  // stale responses are still owed and fetch has not halted.
  assign w_enq = imem_rvalid && !br_taken && (r_drop == '0) && !r_stopped;

  // A redirect flushes the queue, so a concurrent handshake is consumed
  // by decode but must not also pop the (already discarded) head.
  assign w_deq = id_ready && !br_taken;

  // Outstanding count after this cycle's grant and response; a redirect
  // marks exactly this many responses for discard.
  always_comb begin
    w_outAfter = r_outstanding;
    if (w_fire && !imem_rvalid) begin
      w_outAfter = r_outstanding + CNT_ONE;
    end else if (!w_fire && imem_rvalid) begin
      w_outAfter = r_outstanding - CNT_ONE;
    end
  end

  always_comb begin
    w_enqEntry     = '0;
    w_enqEntry.ir  = imem_rdata;
    w_enqEntry.npc = {{(32 - AW){1'b0}}, r_respPc + ADDR_ONE};
  end

  // PC, response tracking, discard counter and halt flag. A redirect takes
  // priority over all ordinary updates except the outstanding bookkeeping.
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_pc          <= RESET_PC_W;
      r_respPc      <= RESET_PC_W;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_stopped     <= 1'b0;
    end else if (br_taken) begin
      r_pc          <= w_target;
      r_respPc      <= w_target;
      r_outstanding <= w_outAfter;
      r_drop        <= w_outAfter;
      r_stopped     <= 1'b0;
    end else begin
      r_outstanding <= w_outAfter;
      if (w_fire) begin
        r_pc <= r_pc + ADDR_ONE;
      end
      if (imem_rvalid && (r_drop != '0)) begin
        r_drop <= r_drop - CNT_ONE;
      end
      if (w_enq) begin
        r_respPc <= r_respPc + ADDR_ONE;
        if (isHalt(imem_rdata)) begin
          r_stopped <= 1'b1;
        end
      end
    end
  end

  mips32_fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk   (clk1),
    .i_reset (reset),
    .i_enq   (w_enq),
    .i_entry (w_enqEntry),
    .i_deq   (w_deq),
    .i_flush (br_taken),
    .o_valid (id_valid),
    .o_head  (w_head),
    .o_count (w_occ)
  );

  assign imem_req     = w_req;
  assign imem_addr    = r_pc;
  assign id_ir        = w_head.ir;
  assign id_npc       = w_head.npc;
  assign fetch_halted = r_stopped;

  // The memory must never answer a request that was not issued
  assert property (@(posedge clk1) disable iff (reset)
    !(imem_rvalid && (r_outstanding == '0)));

endmodule
